// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I widths, fetch entry type and opcode constants
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    // One buffered fetch result: the instruction word and the address it came from.
    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Major opcodes, instr[6:0]; shared by fetch and decode.
    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_e;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - pipelined instruction memory request/response bus
interface fetch_unit_if;
    import riscv_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;

    // Fetch side issues requests and consumes responses.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    // Memory side accepts requests and returns in-order responses.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO of fetch entries with dominant flush
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic [CW-1:0] count,
    output logic         empty,
    output logic         full
);

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A flush wins over any push or pop in the same cycle; popping empty is a no-op.
    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & (count_q != '0);

    // Entry storage; cleared on reset so the head reads as a zero instruction at pc 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Read/write pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage: PC, request credits, response buffering, redirect
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_unit_if.master     imem,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [ILEN-1:0]  if_instr,
    output logic [XLEN-1:0]  if_pc,
    output logic [XLEN-1:0]  if_pc_plus4
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] resp_pc_q;
    logic [CW-1:0]   outst_q;
    logic [CW-1:0]   drop_q;

    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_full;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;

    logic [XLEN-1:0] redirect_tgt;
    logic [CW:0]     credit_sum;
    logic            pop;
    logic            push;
    logic            issue;
    logic            fire;
    logic            rsp;

    // Redirect targets are forced to a word boundary.
    assign redirect_tgt = redirect_pc & ~XLEN'(3);

    assign if_valid = ~fifo_empty;
    assign pop      = if_valid & if_ready;

    // In-flight plus buffered entries, minus the slot freed this cycle; one extra
    // bit so the sum of two DEPTH-bounded counters cannot wrap.
    always_comb begin
        credit_sum = {1'b0, outst_q} + {1'b0, fifo_count} - (CW + 1)'(pop);
    end

    // Requests stop during reset and in a redirect cycle so the new PC goes out first.
    assign issue = rst_n & ~redirect_valid & (credit_sum < DEPTH_W);
    assign fire  = issue & imem.imem_gnt;

    // A response with nothing in flight has no owner and is ignored.
    assign rsp  = imem.imem_rvalid & (outst_q != '0);
    assign push = rsp & (drop_q == '0) & ~redirect_valid;

    assign push_entry.instr = imem.imem_rdata;
    assign push_entry.pc    = resp_pc_q;

    assign imem.imem_req  = issue;
    assign imem.imem_addr = pc_q;

    // PC, expected-response PC and the in-flight/discard counters; redirect takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            outst_q   <= '0;
            drop_q    <= '0;
        end else if (redirect_valid) begin
            pc_q      <= redirect_tgt;
            resp_pc_q <= redirect_tgt;
            outst_q   <= outst_q - CW'(rsp);
            drop_q    <= outst_q - CW'(rsp);
        end else begin
            if (fire) begin
                pc_q <= pc_q + XLEN'(4);
            end
            outst_q <= outst_q + CW'(fire) - CW'(rsp);
            if (rsp) begin
                if (drop_q != '0) begin
                    drop_q <= drop_q - 1'b1;
                end else begin
                    resp_pc_q <= resp_pc_q + XLEN'(4);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (push_entry),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign if_instr    = head.instr;
    assign if_pc       = head.pc;
    assign if_pc_plus4 = head.pc + XLEN'(4);

    a_rvalid_owned: assert property (@(posedge clk) disable iff (!rst_n)
        imem.imem_rvalid |-> (outst_q != '0));

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        w_if_valid;
    logic [31:0] w_if_instr;
    logic [31:0] w_if_pc;
    logic [31:0] w_if_pc_plus4;

    fetch_unit_if mif ();
    fetch_unit_if wif ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (mif),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) u_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (wif),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .if_valid       (w_if_valid),
        .if_ready       (1'b1),
        .if_instr       (w_if_instr),
        .if_pc          (w_if_pc),
        .if_pc_plus4    (w_if_pc_plus4)
    );

    // Memory in flight: address, cycle its response is due, redirect epoch it belongs to.
    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    mreq_t       memq[$];
    int          cyc;
    int          epoch;
    int          buffered;
    logic [31:0] req_pc;
    logic [31:0] out_pc;
    int          gnt_pct;
    int          ready_pct;
    int          redir_pm;
    int          lat;
    bit          pend_redir;
    logic [31:0] pend_pc;
    bit          last_redir;
    logic        w_prev_req;
    logic [31:0] w_prev_addr;
    int          total;
    int          bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        memq.delete();
        epoch++;
        buffered   = 0;
        req_pc     = 32'h0;
        out_pc     = 32'h0;
        w_prev_req = 1'b0;
        last_redir = 1'b0;
        pend_redir = 1'b0;
    endtask

    // Hold reset for two edges, check the reset-state outputs, release mid-cycle.
    task automatic reset_tail();
        redirect_valid   = 1'b0;
        if_ready         = 1'b0;
        mif.imem_gnt     = 1'b0;
        mif.imem_rvalid  = 1'b0;
        mif.imem_rdata   = 32'h0;
        wif.imem_gnt     = 1'b0;
        wif.imem_rvalid  = 1'b0;
        wif.imem_rdata   = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset if_valid", 32'(if_valid), 32'd0);
        chk("reset imem_req", 32'(mif.imem_req), 32'd0);
        chk("reset if_pc", if_pc, 32'h0);
        chk("reset if_instr", if_instr, 32'h0);
        chk("reset if_pc_plus4", if_pc_plus4, 32'h4);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Called at a negedge: assert reset part-way through the low phase.
    task automatic reset_mid();
        #3 rst_n = 1'b0;
        #1;
        chk("async if_valid", 32'(if_valid), 32'd0);
        chk("async imem_req", 32'(mif.imem_req), 32'd0);
        reset_tail();
    endtask

    // One clock: drive inputs after the edge, compare against the model at the negedge,
    // then advance the model by the events that the next edge commits.
    task automatic step();
        logic  exp_valid;
        logic  exp_req;
        logic  pop;
        logic  rv;
        logic  rsp;
        int    d;
        mreq_t e;
        @(posedge clk);
        #1;
        cyc++;
        rsp = 1'b0;
        if (memq.size() > 0) begin
            if (memq[0].due <= cyc) rsp = 1'b1;
        end
        mif.imem_rvalid = rsp;
        mif.imem_rdata  = rsp ? (memq[0].addr ^ KEY) : 32'hDEAD_BEEF;
        mif.imem_gnt    = ($urandom_range(99) < gnt_pct);
        if_ready        = ($urandom_range(99) < ready_pct);
        rv = 1'b0;
        if (pend_redir) begin
            rv          = 1'b1;
            redirect_pc = pend_pc;
            pend_redir  = 1'b0;
        end else if (!last_redir && ($urandom_range(999) < redir_pm)) begin
            rv          = 1'b1;
            redirect_pc = $urandom;
        end
        redirect_valid  = rv;
        last_redir      = rv;
        wif.imem_gnt    = 1'b1;
        wif.imem_rvalid = w_prev_req;
        wif.imem_rdata  = w_prev_addr ^ KEY;
        @(negedge clk);

        exp_valid = (buffered > 0);
        chk("if_valid", 32'(if_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("if_pc", if_pc, out_pc);
            chk("if_instr", if_instr, out_pc ^ KEY);
            chk("if_pc_plus4", if_pc_plus4, out_pc + 32'd4);
        end
        pop     = exp_valid & if_ready;
        exp_req = !rv && ((memq.size() + buffered - int'(pop)) < DEPTH);
        chk("imem_req", 32'(mif.imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", mif.imem_addr, req_pc);

        w_prev_req  = wif.imem_req;
        w_prev_addr = wif.imem_addr;

        if (rv) begin
            if (rsp) void'(memq.pop_front());
            epoch++;
            buffered = 0;
            req_pc   = redirect_pc & ~32'h3;
            out_pc   = req_pc;
        end else begin
            if (rsp) begin
                e = memq.pop_front();
                if (e.epoch == epoch) buffered++;
            end
            if (pop) begin
                buffered--;
                out_pc = out_pc + 32'd4;
            end
            if (exp_req && mif.imem_gnt) begin
                d = cyc + lat;
                if (memq.size() > 0 && memq[$].due >= d) d = memq[$].due + 1;
                memq.push_back('{addr: req_pc, due: d, epoch: epoch});
                req_pc = req_pc + 32'd4;
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        epoch = 0;
        lat   = 1;
        gnt_pct = 100;
        ready_pct = 100;
        redir_pm = 0;
        pend_pc = 32'h0;
        w_prev_addr = 32'h0;
        redirect_pc = 32'h0;
        rst_n = 1'b0;
        model_reset();
        reset_tail();

        // Streaming from reset, L = 1, always ready.
        step();
        chk("first req", 32'(mif.imem_req), 32'd1);
        chk("first addr", mif.imem_addr, 32'h0);
        chk("wrap addr0", wif.imem_addr, 32'hFFFF_FFFC);
        step();
        chk("second addr", mif.imem_addr, 32'h4);
        chk("wrap addr1", wif.imem_addr, 32'h0000_0000);
        step();
        chk("first valid", 32'(if_valid), 32'd1);
        chk("first pc", if_pc, 32'h0);
        chk("first instr", if_instr, 32'hA5A5_0000);
        chk("wrap pc", w_if_pc, 32'hFFFF_FFFC);
        chk("wrap pc_plus4", w_if_pc_plus4, 32'h0);
        chk("wrap instr", w_if_instr, 32'h5A5A_FFFC);
        step();
        chk("second pc", if_pc, 32'h4);
        chk("second instr", if_instr, 32'hA5A5_0004);

        // Backpressure: five cycles of not-ready.
        ready_pct = 0;
        repeat (5) step();
        chk("bp valid", 32'(if_valid), 32'd1);
        chk("bp head pc", if_pc, 32'h8);
        chk("bp req", 32'(mif.imem_req), 32'd0);
        ready_pct = 100;
        repeat (10) step();

        // Misaligned redirect landing on a cycle with a response and a pop.
        pend_redir = 1'b1;
        pend_pc    = 32'h203;
        step();
        chk("coinc rvalid", 32'(mif.imem_rvalid), 32'd1);
        chk("coinc pop", 32'(if_valid & if_ready), 32'd1);
        step();
        chk("redir+1 valid", 32'(if_valid), 32'd0);
        chk("redir+1 req", 32'(mif.imem_req), 32'd1);
        chk("redir+1 addr", mif.imem_addr, 32'h200);
        step();
        step();
        chk("redir+3 valid", 32'(if_valid), 32'd1);
        chk("redir+3 pc", if_pc, 32'h200);

        // Redirect with two responses in flight, L = 3.
        lat = 3;
        for (int i = 0; i < 30 && memq.size() != 2; i++) step();
        chk("inflight budget", 32'(memq.size()), 32'd2);
        pend_redir = 1'b1;
        pend_pc    = 32'h100;
        step();
        step();
        chk("stale valid", 32'(if_valid), 32'd0);
        for (int i = 0; i < 20 && !if_valid; i++) step();
        chk("stale next pc", if_pc, 32'h100);
        step();
        for (int i = 0; i < 20 && !if_valid; i++) step();
        chk("stale following pc", if_pc, 32'h104);

        // Asynchronous reset with two requests outstanding.
        for (int i = 0; i < 30 && memq.size() != 2; i++) step();
        chk("reset inflight budget", 32'(memq.size()), 32'd2);
        reset_mid();
        lat = 1;
        step();
        chk("post-reset addr", mif.imem_addr, 32'h0);

        // Randomized segments: latency, grant rate, decode readiness, redirects.
        for (int s = 0; s < 12; s++) begin
            lat       = $urandom_range(1, 4);
            gnt_pct   = $urandom_range(40, 100);
            ready_pct = $urandom_range(20, 100);
            redir_pm  = $urandom_range(0, 60);
            repeat (250) step();
            if (s == 6) reset_mid();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
